// File: rtl/sym_err_meter.sv
`default_nettype none
// ============================================================================
//  Module      : sym_err_meter
//  Description : 4-ASK symbol-error meter. Finds the tx->rx symbol delay by
//                trial search, then counts symbols/errors per strobe window.
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_err_meter #(
  parameter int MAX_DELAY   = 16,
  parameter int DELAY_W     = 4,
  parameter int TRIAL_LEN   = 64,
  parameter int LOCK_THRESH = 2,
  parameter int CNT_W       = 22
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clk_en_i,
  input  logic [1:0]         sym_tx_i,
  input  logic [1:0]         sym_rx_i,
  input  logic               window_strobe_i,
  output logic [CNT_W-1:0]   err_count_o,
  output logic [CNT_W-1:0]   sym_count_o,
  output logic               result_valid_o,
  output logic               locked_o,
  output logic [DELAY_W-1:0] delay_sel_o,
  output logic               err_flag_o
);

  localparam int NTAP   = 2**DELAY_W;
  localparam int TCNT_W = (TRIAL_LEN > 1) ? $clog2(TRIAL_LEN) : 1;
  localparam int TERR_W = $clog2(TRIAL_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_SEARCH   = 2'd0,
    S_WAIT_WIN = 2'd1,
    S_MEASURE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [1:0]         dly_q [MAX_DELAY-1];
  logic [1:0]         tap   [NTAP];
  logic [TCNT_W-1:0]  trial_cnt_q;
  logic [TERR_W-1:0]  trial_err_q, trial_err_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   err_count_q, sym_count_q;
  logic               result_valid_q, locked_q, err_flag_q;
  logic [DELAY_W-1:0] delay_sel_q, delay_sel_d;
  logic               mismatch, lose_lock;

  // Unused tap slots beyond MAX_DELAY read as zero so delay_sel indexes a full array.
  for (genvar d = 0; d < NTAP; d++) begin : g_tap
    if (d == 0) begin : g_cur
      assign tap[d] = sym_tx_i;
    end else if (d < MAX_DELAY) begin : g_dly
      assign tap[d] = dly_q[d-1];
    end else begin : g_pad
      assign tap[d] = 2'b00;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < MAX_DELAY-1; i++) dly_q[i] <= 2'b00;
    end else if (clk_en_i) begin
      dly_q[0] <= sym_tx_i;
      for (int i = 1; i < MAX_DELAY-1; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  always_comb begin
    mismatch    = (sym_rx_i != tap[delay_sel_q]);
    trial_err_d = trial_err_q + TERR_W'(mismatch);
    sym_cnt_d   = (sym_cnt_q == CNT_MAX) ? sym_cnt_q : sym_cnt_q + CNT_W'(1);
    err_cnt_d   = (mismatch && (err_cnt_q != CNT_MAX)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    delay_sel_d = (delay_sel_q == DELAY_W'(MAX_DELAY-1)) ? '0 : delay_sel_q + DELAY_W'(1);
    lose_lock   = ({err_cnt_q, 2'b00} > {2'b00, sym_cnt_q});
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_SEARCH;
      trial_cnt_q    <= '0;
      trial_err_q    <= '0;
      sym_cnt_q      <= '0;
      err_cnt_q      <= '0;
      err_count_q    <= '0;
      sym_count_q    <= '0;
      result_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      delay_sel_q    <= '0;
      err_flag_q     <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (clk_en_i) begin
        err_flag_q <= mismatch;
        case (state_q)
          S_SEARCH: begin
            // The last trial symbol's mismatch is folded in via trial_err_d.
            if (trial_cnt_q == TCNT_W'(TRIAL_LEN-1)) begin
              trial_cnt_q <= '0;
              trial_err_q <= '0;
              if (trial_err_d <= TERR_W'(LOCK_THRESH)) begin
                locked_q <= 1'b1;
                state_q  <= S_WAIT_WIN;
              end else begin
                delay_sel_q <= delay_sel_d;
              end
            end else begin
              trial_cnt_q <= trial_cnt_q + TCNT_W'(1);
              trial_err_q <= trial_err_d;
            end
          end
          S_WAIT_WIN: begin
            if (window_strobe_i) begin
              sym_cnt_q <= CNT_W'(1);
              err_cnt_q <= CNT_W'(mismatch);
              state_q   <= S_MEASURE;
            end
          end
          S_MEASURE: begin
            if (window_strobe_i) begin
              err_count_q    <= err_cnt_q;
              sym_count_q    <= sym_cnt_q;
              result_valid_q <= 1'b1;
              sym_cnt_q      <= CNT_W'(1);
              err_cnt_q      <= CNT_W'(mismatch);
              if (lose_lock) begin
                locked_q    <= 1'b0;
                delay_sel_q <= delay_sel_d;
                state_q     <= S_SEARCH;
              end
            end else begin
              sym_cnt_q <= sym_cnt_d;
              err_cnt_q <= err_cnt_d;
            end
          end
          default: state_q <= S_SEARCH;
        endcase
      end
    end
  end

  assign err_count_o    = err_count_q;
  assign sym_count_o    = sym_count_q;
  assign result_valid_o = result_valid_q;
  assign locked_o       = locked_q;
  assign delay_sel_o    = delay_sel_q;
  assign err_flag_o     = err_flag_q;

endmodule
`default_nettype wire

// File: doc/sym_err_meter.md
Name: sym_err_meter

Overview:
Symbol-error measurement stage downstream of the 4-ASK slicer. It self-aligns the transmitted symbol stream to the sliced receive stream by searching over symbol delays. Once aligned, it counts symbols and symbol errors over windows framed by the LFSR periodic cycle pulse. It latches per-window results for SignalTap/display and replaces the fixed compile-time symbol-delay alignment.

Parameters:
MAX_DELAY, 16, number of symbol delay taps searched (0..MAX_DELAY-1)
DELAY_W, 4, width of delay_sel; must satisfy 2**DELAY_W >= MAX_DELAY
TRIAL_LEN, 64, symbols per alignment trial
LOCK_THRESH, 2, max errors in a trial for that delay to be accepted
CNT_W, 22, width of the symbol and error counters

Ports:
clk  in  1  system clock (sys_clk domain)
reset  in  1  asynchronous, active-high reset
clk_en  in  1  symbol-rate enable (sym_clk_ena); all state advances only when high
sym_tx  in  2  transmitted in-phase symbol bits from the LFSR
sym_rx  in  2  sliced receive symbol from the 4-ASK slicer
window_strobe  in  1  window boundary (lfsr_cycle_out_periodic); sampled only when clk_en=1
err_count  out  CNT_W  errors in last completed window
sym_count  out  CNT_W  symbols in last completed window
result_valid  out  1  one-clk pulse when err_count/sym_count update
locked  out  1  alignment found and held
delay_sel  out  DELAY_W  current alignment tap
err_flag  out  1  registered per-symbol mismatch

Behaviour:
- Reset (async): delay line cleared to 0. State = SEARCH. All counters 0. All outputs 0, including delay_sel.
- Delay line: MAX_DELAY-1 registers, shifting sym_tx on clk_en only. Tap 0 = sym_tx (current). Tap d = sym_tx from d enabled samples earlier.
- Per clk_en: mismatch = (sym_rx != tap[delay_sel]). err_flag <= mismatch, registered, so it is valid 1 clk after the enabled cycle. err_flag updates in all states.
- SEARCH:
  - trial_cnt counts clk_en from 0 to TRIAL_LEN-1; trial_err accumulates mismatches.
  - The final symbol of the trial is included in the decision.
  - If trial_err <= LOCK_THRESH: locked <= 1, go to WAIT_WIN.
  - Otherwise: delay_sel increments, wrapping MAX_DELAY-1 -> 0; trial counters clear; a new trial starts on the next clk_en.
  - window_strobe is ignored in SEARCH.
- WAIT_WIN:
  - On clk_en && window_strobe: go to MEASURE.
  - The strobe symbol itself is counted as the first symbol: sym_cnt=1, err_cnt=mismatch.
- MEASURE:
  - Each clk_en without a strobe: sym_cnt+1; err_cnt+mismatch.
  - On clk_en && window_strobe: err_count/sym_count <= accumulated values, excluding the strobe symbol. result_valid pulses high for exactly 1 clk. Counters restart with the strobe symbol counted, as in WAIT_WIN.
- Loss of lock, evaluated at each window close:
  - If 4*err_count_latched > sym_count_latched: locked <= 0, delay_sel <= delay_sel+1 (wrapping), go to SEARCH with fresh trial.
  - Latched results and result_valid still emit for that window.
- Saturation: sym_cnt and err_cnt each saturate at 2**CNT_W-1 and never wrap. Comparison arithmetic uses CNT_W+2 bits.
- Without clk_en, all registers hold, except result_valid, which returns to 0 the clk after its pulse.
- Reset asserted mid-operation returns to the reset state immediately, regardless of state.

Test Plan:
1. Random sym_tx; sym_rx = sym_tx delayed 5 symbols; release reset. Required: locked=1 after 6*64=384 enabled symbols, delay_sel=5, state WAIT_WIN.
2. Continuing from 1 with strobes 1000 symbols apart. Required: at the second strobe, result_valid pulses for 1 clk, sym_count=1000, err_count=0, locked stays 1.
3. Continuing from 2, corrupt exactly 3 symbols inside one window. Required: that window reports err_count=3, sym_count=1000. err_flag is high on the 3 corresponding cycles, each 1 clk after clk_en.
4. While locked, force sym_rx=0 with random tx for one full window. Required: err_count ≈750 (>250), locked falls to 0, delay_sel=6, and re-lock returns delay_sel to 5 after a wrap search.
5. CNT_W=8, locked, window of 300 symbols all in error. Required: err_count=255, sym_count=255.
6. Assert reset for 1 clk mid-MEASURE. Required: locked=0, delay_sel=0, err_count=0, sym_count=0, result_valid=0 immediately (async); search restarts from delay 0.
